process_scheduler: RTL and testbench
====================================

PROCESS_SCHEDULER -- requirements
Module: process_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_WIDTH, 12, instruction address width.
- NUM_PROC, 10, number of process slots.
- PART_BASE, 1, word address of slot 0.
- PART_SIZE, 100, words per slot.
- QUANTUM_W, 8, width of the time-slice counter.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1, single clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a scheduling run.
- ready_mask, input, NUM_PROC, slot i holds a loaded process.
- proc_done, input, 1, one-cycle pulse: the current process exited.
- quantum, input, QUANTUM_W, time slice in cycles.
- ctx_ack, input, 1, the context-save/restore routine has completed.
- ctx_req, output, 1, context switch requested.
- pc_load, output, 1, one-cycle pulse: load pc_target into the PC.
- pc_target, output, ADDR_WIDTH, entry address of the selected slot.
- cur_pid, output, 4, index of the running slot.
- preempted, output, 1, one-cycle pulse on quantum expiry.
- busy, output, 1, high in every state except IDLE and FINISH.
- all_done, output, 1, every ready slot has finished.

Function
REQ-003 The FSM SHALL have five states: IDLE, SELECT, SWITCH, RUN and FINISH.
REQ-004 In IDLE or FINISH, start=1 SHALL clear the finished mask and all_done, and move to SELECT on the next cycle; start SHALL be ignored in every other state.
REQ-005 SELECT SHALL last exactly one cycle and sample ready_mask.
- The eligible set is ready_mask AND NOT finished.
- The next pid is the lowest eligible index strictly greater than cur_pid, wrapping modulo NUM_PROC.
- The first selection after start SHALL begin its search at index 0.
REQ-006 If no slot is eligible, SELECT SHALL go to FINISH and set all_done=1; all_done SHALL stay high until the next start.
REQ-007 In SWITCH, ctx_req SHALL be held high until ctx_ack=1. In the ack cycle:
- pc_load pulses for one cycle;
- pc_target = PART_BASE + pid*PART_SIZE (truncated to ADDR_WIDTH);
- cur_pid updates;
- the state moves to RUN.
REQ-008 ctx_ack SHALL be ignored outside SWITCH.
REQ-009 On RUN entry the slice counter SHALL load quantum; a quantum of 0 SHALL mean 2^QUANTUM_W cycles. The counter SHALL decrement once per RUN cycle.
REQ-010 In RUN, proc_done=1 SHALL set finished[cur_pid] and move to SELECT.
REQ-011 If proc_done and quantum expiry occur in the same cycle, proc_done SHALL win and preempted SHALL not pulse.
REQ-012 If the sole eligible slot is preempted, it SHALL be reselected and SHALL go through SWITCH again.
REQ-013 pc_target and cur_pid SHALL hold their values between pc_load pulses.

Reset
REQ-014 When rst_n=0, the block SHALL immediately reset to:
- state IDLE;
- every output 0;
- finished mask 0;
- counter 0;
- internal search pointer set so the next search starts at 0.
REQ-015 A reset during SWITCH or RUN SHALL abandon the operation, and no pc_load SHALL follow reset release without a new start.

Configuration
REQ-016 With SCHED_PREEMPT_EN defined, RUN SHALL move to SELECT and pulse preempted when the counter reaches its last cycle (the quantum-th RUN cycle).
REQ-017 Without SCHED_PREEMPT_EN, the block SHALL have no slice counter. RUN SHALL leave only on proc_done, preempted SHALL be tied to 0, and quantum SHALL be unused.

Structure
REQ-018 The state enum, PART_BASE, PART_SIZE, NUM_PROC and the OS routine addresses SHALL live in a shared package, process_sched_pkg.
REQ-019 The wrap-around next-eligible search SHALL be a combinational sub-module, rr_pick (inputs: mask and start index; outputs: index and found).

Verification
REQ-020 Reset, then start with ready_mask=10'h3FF, ctx_ack one cycle after every ctx_req, and no proc_done. The bench SHALL check:
- pc_target sequence 1, 101, 201, …, 901, 1 (wrap);
- no pc_load before start.
REQ-021 Set ready_mask=10'b0000100101 and quantum=5, with SCHED_PREEMPT_EN defined. The bench SHALL check:
- pids 0, 2, 5, 0;
- preempted pulses 5 RUN cycles after each pc_load.
REQ-022 Assert proc_done in the same cycle as quantum expiry on pid 3. The bench SHALL check:
- finished[3]=1;
- preempted=0;
- pid 3 never reselected.
REQ-023 Finish every ready slot using ready_mask=10'b1000000001. The bench SHALL check:
- all_done=1 after the second proc_done;
- state FINISH;
- busy=0.
REQ-024 Hold ctx_ack low for 20 cycles in SWITCH, then drop rst_n. The bench SHALL check:
- ctx_req held high for all 20 cycles;
- all outputs 0 immediately on reset;
- no pc_load after reset release.
REQ-025 Build without SCHED_PREEMPT_EN and use quantum=1. The bench SHALL check:
- no switch occurs until proc_done;
- preempted is constantly 0.

Source files
------------

// File: rtl/process_sched_pkg.sv
// Shared scheduler definitions: FSM state encoding, partition layout and
// the fixed entry points of the OS context-switch routines.
package process_sched_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      SWITCH = 3'd2,
      RUN    = 3'd3,
      FINISH = 3'd4
   } sched_state_t;

   localparam int NUM_PROC  = 10;
   localparam int PART_BASE = 1;
   localparam int PART_SIZE = 100;

   // Entry points of the save/restore routine that raises ctx_ack.
   localparam logic [11:0] CTX_SAVE_ADDR    = 12'hF00;
   localparam logic [11:0] CTX_RESTORE_ADDR = 12'hF40;

endpackage

// File: rtl/rr_pick.sv
// Wrap-around picker: lowest set bit of mask at or after start_idx,
// continuing from index 0 when the top of the mask is passed.
module rr_pick #(
   parameter int N    = 10,
   parameter int IDXW = 4
) (
   input  logic [N-1:0]    mask,
   input  logic [IDXW-1:0] start_idx,
   output logic [IDXW-1:0] idx,
   output logic            found
);

   logic [N-1:0] rotated;

   always_comb begin
      rotated = N'({mask, mask} >> start_idx);
      idx     = '0;
      found   = 1'b0;
      // Descending scan so the smallest offset from start_idx is kept last.
      for (int k = N - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            found = 1'b1;
            if (k >= N - int'(start_idx))
               idx = start_idx + IDXW'(k) - IDXW'(N);
            else
               idx = start_idx + IDXW'(k);
         end
      end
   end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin process scheduler with a context-switch handshake.
// Define SCHED_PREEMPT_EN to add the time-slice counter and preemption.
module process_scheduler
   import process_sched_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_PROC   = process_sched_pkg::NUM_PROC,
   parameter int PART_BASE  = process_sched_pkg::PART_BASE,
   parameter int PART_SIZE  = process_sched_pkg::PART_SIZE,
   parameter int QUANTUM_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [NUM_PROC-1:0]   ready_mask,
   input  logic                  proc_done,
   input  logic [QUANTUM_W-1:0]  quantum,
   input  logic                  ctx_ack,
   output logic                  ctx_req,
   output logic                  pc_load,
   output logic [ADDR_WIDTH-1:0] pc_target,
   output logic [3:0]            cur_pid,
   output logic                  preempted,
   output logic                  busy,
   output logic                  all_done,
   output sched_state_t          state_dbg
);

   localparam int PIDW = 4;

   sched_state_t          state;
   logic [NUM_PROC-1:0]   finished;
   logic [NUM_PROC-1:0]   eligible;
   logic [PIDW-1:0]       search_from;
   logic [PIDW-1:0]       sel_pid;
   logic [PIDW-1:0]       pick_idx;
   logic                  pick_found;
   logic [PIDW-1:0]       after_cur;
   logic [ADDR_WIDTH-1:0] target_next;

   assign eligible    = ready_mask & ~finished;
   assign after_cur   = (cur_pid == PIDW'(NUM_PROC - 1)) ? '0 : cur_pid + PIDW'(1);
   assign target_next = ADDR_WIDTH'(PART_BASE) + ADDR_WIDTH'(sel_pid) * ADDR_WIDTH'(PART_SIZE);
   assign state_dbg   = state;

   rr_pick #(.N(NUM_PROC), .IDXW(PIDW)) u_pick (
      .mask      (eligible),
      .start_idx (search_from),
      .idx       (pick_idx),
      .found     (pick_found)
   );

`ifdef SCHED_PREEMPT_EN
   // Loaded with quantum on RUN entry; a quantum of 0 wraps to 2^QUANTUM_W cycles.
   logic [QUANTUM_W-1:0] slice_cnt;
   logic                 slice_last;
   assign slice_last = (slice_cnt == QUANTUM_W'(1));
`else
   logic unused_quantum;
   assign unused_quantum = ^quantum;
   assign preempted      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         finished    <= '0;
         search_from <= '0;
         sel_pid     <= '0;
         cur_pid     <= '0;
         pc_target   <= '0;
         pc_load     <= 1'b0;
         ctx_req     <= 1'b0;
         busy        <= 1'b0;
         all_done    <= 1'b0;
`ifdef SCHED_PREEMPT_EN
         preempted   <= 1'b0;
         slice_cnt   <= '0;
`endif
      end else begin
         pc_load <= 1'b0;
`ifdef SCHED_PREEMPT_EN
         preempted <= 1'b0;
`endif
         case (state)
            IDLE, FINISH: begin
               if (start) begin
                  finished    <= '0;
                  all_done    <= 1'b0;
                  search_from <= '0;
                  busy        <= 1'b1;
                  state       <= SELECT;
               end
            end
            SELECT: begin
               if (pick_found) begin
                  sel_pid <= pick_idx;
                  ctx_req <= 1'b1;
                  state   <= SWITCH;
               end else begin
                  all_done <= 1'b1;
                  busy     <= 1'b0;
                  state    <= FINISH;
               end
            end
            SWITCH: begin
               if (ctx_ack) begin
                  ctx_req   <= 1'b0;
                  pc_load   <= 1'b1;
                  pc_target <= target_next;
                  cur_pid   <= sel_pid;
                  state     <= RUN;
`ifdef SCHED_PREEMPT_EN
                  slice_cnt <= quantum;
`endif
               end
            end
            RUN: begin
`ifdef SCHED_PREEMPT_EN
               slice_cnt <= slice_cnt - QUANTUM_W'(1);
`endif
               // proc_done takes priority over a slice expiring in the same cycle.
               if (proc_done) begin
                  finished[cur_pid] <= 1'b1;
                  search_from       <= after_cur;
                  state             <= SELECT;
               end
`ifdef SCHED_PREEMPT_EN
               else if (slice_last) begin
                  preempted   <= 1'b1;
                  search_from <= after_cur;
                  state       <= SELECT;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_process_scheduler.sv
// Self-checking bench for process_scheduler; covers both the default build
// and the SCHED_PREEMPT_EN build.
module tb_process_scheduler;
   import process_sched_pkg::*;

   localparam int NP = 10;
`ifdef SCHED_PREEMPT_EN
   localparam bit PRE_EN   = 1'b1;
   localparam int T1_LOADS = 11;
`else
   localparam bit PRE_EN   = 1'b0;
   localparam int T1_LOADS = 10;
`endif

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic          start      = 1'b0;
   logic [NP-1:0] ready_mask = '0;
   logic          proc_done  = 1'b0;
   logic [7:0]    quantum    = 8'd0;
   logic          ctx_ack    = 1'b0;
   logic          ctx_req, pc_load, preempted, busy, all_done;
   logic [11:0]   pc_target;
   logic [3:0]    cur_pid;
   sched_state_t  state_dbg;

   int checks = 0;
   int errors = 0;
   bit ack_en = 1'b1;
   int ack_delay = 1;

   int tgt_tab[11] = '{1, 101, 201, 301, 401, 501, 601, 701, 801, 901, 1};
   int seq2[4]     = '{0, 2, 5, 0};

   process_scheduler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .ready_mask (ready_mask),
      .proc_done  (proc_done),
      .quantum    (quantum),
      .ctx_ack    (ctx_ack),
      .ctx_req    (ctx_req),
      .pc_load    (pc_load),
      .pc_target  (pc_target),
      .cur_pid    (cur_pid),
      .preempted  (preempted),
      .busy       (busy),
      .all_done   (all_done),
      .state_dbg  (state_dbg)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + scoreboard ----------------
   logic [3:0]    exp_q[$];
   logic [NP-1:0] m_fin;
   int  m_prev, m_q, run_cnt;
   bit  m_active, m_done, m_done_pending, m_wait_sel, in_run;

   function automatic int pick_next(input logic [NP-1:0] elig, input int prev);
      for (int k = 1; k <= NP; k++) begin
         int i;
         i = (prev + k) % NP;
         if (elig[i]) return i;
      end
      return -1;
   endfunction

   initial begin
      bit was_active;
      bit exp_pre;
      int pid;
      m_active = 0; m_done = 0; m_done_pending = 0; m_wait_sel = 0; in_run = 0;
      m_fin = '0; m_prev = -1; m_q = 256; run_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         exp_pre = 1'b0;
         if (!rst_n) begin
            m_active = 0; m_done = 0; m_done_pending = 0; m_wait_sel = 0; in_run = 0;
         end else begin
            was_active = m_active;
            if (m_done_pending) begin
               m_done_pending = 0; m_active = 0; m_done = 1;
            end
            if (start && !was_active) begin
               m_active = 1; m_done = 0; m_fin = '0; m_prev = -1;
               m_wait_sel = 1; in_run = 0;
            end else if (in_run) begin
               run_cnt++;
               exp_pre = PRE_EN && !proc_done && (run_cnt == m_q);
               if (proc_done) m_fin[m_prev] = 1'b1;
               if (proc_done || exp_pre) begin
                  in_run = 0;
                  if ((ready_mask & ~m_fin) == '0) m_done_pending = 1;
                  else m_wait_sel = 1;
               end
            end
         end
         check("preempted", preempted, exp_pre);
         check("busy", busy, m_active);
         check("all_done", all_done, m_done);
         if (!m_wait_sel) begin
            check("no_pc_load", pc_load, 0);
         end else if (pc_load) begin
            pid = pick_next(ready_mask & ~m_fin, m_prev);
            exp_q.push_back(4'(pid));
            check("model_cur_pid", cur_pid, pid);
            check("model_pc_target", pc_target, (1 + pid * 100) % 4096);
            m_prev = pid; m_wait_sel = 0; in_run = 1; run_cnt = 0;
            m_q = (quantum == 8'd0) ? 256 : int'(quantum);
         end
      end
   end

   // context-switch routine stand-in: acks ack_delay cycles after ctx_req rises
   initial begin
      int req_cnt;
      req_cnt = 0;
      forever begin
         @(negedge clk);
         if (ack_en && ctx_req && rst_n) begin
            req_cnt++;
            ctx_ack = (req_cnt > ack_delay);
         end else begin
            req_cnt = 0;
            ctx_ack = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; start = 1'b0; proc_done = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic pulse_done();
      @(negedge clk); proc_done = 1'b1;
      @(negedge clk); proc_done = 1'b0;
   endtask

   task automatic expect_load(input int budget, input int exp_pid, input int exp_tgt);
      bit seen;
      int mpid;
      seen = 1'b0;
      mpid = -1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (pc_load) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL load_timeout: no pc_load in %0d cycles, expected pid %0d", budget, exp_pid);
      end else begin
         if (exp_q.size() > 0) mpid = int'(exp_q.pop_front());
         check("load_pid", cur_pid, exp_pid);
         check("load_target", pc_target, exp_tgt);
         check("model_pid", mpid, exp_pid);
      end
   endtask

   task automatic preempt_delay(output int n);
      n = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (preempted) begin
            n = c;
            return;
         end
      end
   endtask

   initial begin
      #300000;
      errors++;
      $display("FAIL watchdog: time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int loads;
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("rst_pc_target", pc_target, 0);
      check("rst_cur_pid", cur_pid, 0);
      check("rst_ctx_req", ctx_req, 0);
      check("rst_pc_load", pc_load, 0);
      check("rst_busy", busy, 0);
      check("rst_all_done", all_done, 0);
      check("rst_state", state_dbg, IDLE);
      @(negedge clk);
      rst_n = 1'b1;

      // Full round robin over every slot
      ready_mask = 10'h3FF;
      quantum    = PRE_EN ? 8'd3 : 8'd0;
      loads = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (pc_load) loads++;
      end
      check("pc_load_before_start", loads, 0);
      pulse_start();
      for (int k = 0; k < T1_LOADS; k++) begin
         expect_load(40, k % NP, tgt_tab[k]);
`ifndef SCHED_PREEMPT_EN
         repeat (2) @(negedge clk);
         pulse_done();
`endif
      end

`ifdef SCHED_PREEMPT_EN
      // Preemption order and slice length
      do_reset();
      ready_mask = 10'b0000100101;
      quantum    = 8'd5;
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         expect_load(40, seq2[k], 1 + seq2[k] * 100);
         if (k < 3) begin
            preempt_delay(n);
            check("preempt_delay", n, 5);
         end
      end

      // proc_done collides with slice expiry on pid 3
      do_reset();
      ready_mask = 10'b0000011000;
      quantum    = 8'd4;
      pulse_start();
      expect_load(40, 3, 301);
      repeat (3) @(negedge clk);
      proc_done = 1'b1;
      @(negedge clk);
      proc_done = 1'b0;
      check("collide_preempted", preempted, 0);
      for (int k = 0; k < 3; k++) expect_load(40, 4, 401);
`endif

      // Finish every ready slot
      do_reset();
      ready_mask = 10'b1000000001;
      quantum    = 8'd0;
      pulse_start();
      expect_load(40, 0, 1);
      repeat (2) @(negedge clk);
      pulse_done();
      expect_load(40, 9, 901);
      repeat (2) @(negedge clk);
      pulse_done();
      check("all_done_in_select", all_done, 0);
      @(negedge clk);
      check("fin_all_done", all_done, 1);
      check("fin_state", state_dbg, FINISH);
      check("fin_busy", busy, 0);

      // Stall in SWITCH, then reset
      do_reset();
      ready_mask = 10'b0000001010;
      quantum    = 8'd0;
      pulse_start();
      expect_load(40, 1, 101);
      ack_en = 1'b0;
      @(negedge clk);
      pulse_done();
      for (int c = 0; c < 10 && !ctx_req; c++) @(negedge clk);
      for (int c = 0; c < 20; c++) begin
         check("ctx_req_hold", ctx_req, 1);
         check("switch_state", state_dbg, SWITCH);
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check("async_ctx_req", ctx_req, 0);
      check("async_pc_load", pc_load, 0);
      check("async_pc_target", pc_target, 0);
      check("async_cur_pid", cur_pid, 0);
      check("async_preempted", preempted, 0);
      check("async_busy", busy, 0);
      check("async_all_done", all_done, 0);
      check("async_state", state_dbg, IDLE);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      ack_en = 1'b1;
      loads  = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (pc_load) loads++;
      end
      check("pc_load_after_reset", loads, 0);

`ifndef SCHED_PREEMPT_EN
      // No slice counter: tiny quantum must not cause a switch
      do_reset();
      ready_mask = 10'h3FF;
      quantum    = 8'd1;
      pulse_start();
      expect_load(40, 0, 1);
      loads = 0;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (pc_load) loads++;
         if (preempted) n++;
      end
      check("nopre_switches", loads, 0);
      check("nopre_preempted", n, 0);
      check("nopre_state", state_dbg, RUN);
      pulse_done();
      expect_load(40, 1, 101);
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
